// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trap/redirect sequencer:
//   - target_sel_e : branch-unit target-select encodings
//   - CSR_*        : machine-mode CSR addresses written by the sequencer
//   - state_e      : sequencer state encoding
//   - MSTATUS_*    : mstatus bit positions touched on trap entry / mret
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,  // plain branch/jump target
        SEL_MTVEC = 2'b01,  // exception entry
        SEL_MEPC  = 2'b10,  // mret
        SEL_RSVD  = 2'b11   // no action
    } target_sel_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_SAVE_EPC       = 3'd1,
        ST_SAVE_CAUSE     = 3'd2,
        ST_SAVE_STATUS    = 3'd3,
        ST_RESTORE_STATUS = 3'd4,
        ST_REDIRECT       = 3'd5
    } state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/mstatus_update.sv
// -----------------------------------------------------------------------------
// mstatus_update
// Combinational mstatus rewrite for trap entry and mret.
//   mstatus_i [XLEN] : current mstatus value
//   is_mret_i        : 1 = mret (restore), 0 = trap entry (save)
//   mstatus_o [XLEN] : updated mstatus; all other bits pass through
// Trap entry: MPIE <- MIE, MIE <- 0, MPP <- 2'b11
// mret      : MIE <- MPIE, MPIE <- 1, MPP <- 2'b11
// -----------------------------------------------------------------------------
module mstatus_update
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mstatus_i,
    input  logic            is_mret_i,
    output logic [XLEN-1:0] mstatus_o
);

    always_comb begin
        // NOTE: assign a full default first so no path through the block leaves
        // a bit unassigned; otherwise synthesis infers a latch.
        mstatus_o = mstatus_i;
        if (is_mret_i) begin
            mstatus_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
            mstatus_o[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
            mstatus_o[MSTATUS_MIE]  = 1'b0;
        end
        mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// trap_redirect_ctrl
// Turns EX-stage branch resolution into PC redirects, flushes and the CSR
// writes needed for trap entry and mret. The pipeline is stalled while trap
// state is written, then redirected to the captured target for one cycle.
//
// Build option: TRAP_MSTATUS_EN
//   defined   -> mstatus (0x300) is saved on trap entry and restored on mret
//   undefined -> mstatus is never written and mstatus_i is unused
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   ex_valid_i, branching_i : request qualifier from EX / branch unit
//   target_sel_i [2]        : 00 ALU, 01 MTVEC (trap), 10 MEPC (mret), 11 none
//   alu_target_i, ex_pc_i   : branch target, PC of the EX instruction
//   exc_cause_i [CAUSE_W]   : exception cause code
//   mtvec_i, mepc_i, mstatus_i : current CSR values
//   csr_we_o, csr_waddr_o, csr_wdata_o : CSR write port
//   redirect_o, redirect_pc_o : fetch redirect (single-cycle pulse)
//   flush_o                 : kill IF/ID and ID/EX
//   stall_o                 : hold IF, ID, EX while CSRs are written
//   busy_o                  : sequencer not idle
// -----------------------------------------------------------------------------
module trap_redirect_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ex_valid_i,
    input  logic               branching_i,
    input  logic [1:0]         target_sel_i,
    input  logic [XLEN-1:0]    alu_target_i,
    input  logic [XLEN-1:0]    ex_pc_i,
    input  logic [CAUSE_W-1:0] exc_cause_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic [XLEN-1:0]    mstatus_i,
    output logic               csr_we_o,
    output logic [11:0]        csr_waddr_o,
    output logic [XLEN-1:0]    csr_wdata_o,
    output logic               redirect_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               flush_o,
    output logic               stall_o,
    output logic               busy_o
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    target_q;
    logic [XLEN-1:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               accept;
    logic               unused_bits;

    assign accept = (state_q == ST_IDLE) && ex_valid_i && branching_i;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            epc_q    <= '0;
            cause_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                case (target_sel_e'(target_sel_i))
                    SEL_ALU:   target_q <= alu_target_i;
                    SEL_MTVEC: begin
                        epc_q    <= ex_pc_i;
                        cause_q  <= exc_cause_i;
                        // Direct mode only: the mode bits are forced to zero.
                        target_q <= {mtvec_i[XLEN-1:2], 2'b00};
                    end
                    SEL_MEPC:  target_q <= mepc_i;
                    default:   ;
                endcase
            end
        end
    end

`ifdef TRAP_MSTATUS_EN
    // The rewritten mstatus is registered on the edge that enters the write
    // state, so csr_wdata_o stays a pure register decode with no path from
    // mstatus_i. The CSR file holds mstatus steady across the sequence.
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mstatus_new;

    mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
        .mstatus_i (mstatus_i),
        .is_mret_i (state_d == ST_RESTORE_STATUS),
        .mstatus_o (mstatus_new)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_q <= '0;
        end else if (state_d == ST_SAVE_STATUS || state_d == ST_RESTORE_STATUS) begin
            mstatus_q <= mstatus_new;
        end
    end

    assign unused_bits = ^mtvec_i[1:0];
`else
    assign unused_bits = ^{mtvec_i[1:0], mstatus_i};
`endif

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (target_sel_e'(target_sel_i))
                        SEL_ALU:   state_d = ST_REDIRECT;
                        SEL_MTVEC: state_d = ST_SAVE_EPC;
`ifdef TRAP_MSTATUS_EN
                        SEL_MEPC:  state_d = ST_RESTORE_STATUS;
`else
                        SEL_MEPC:  state_d = ST_REDIRECT;
`endif
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SAVE_EPC:       state_d = ST_SAVE_CAUSE;
`ifdef TRAP_MSTATUS_EN
            ST_SAVE_CAUSE:     state_d = ST_SAVE_STATUS;
            ST_SAVE_STATUS:    state_d = ST_REDIRECT;
            ST_RESTORE_STATUS: state_d = ST_REDIRECT;
`else
            ST_SAVE_CAUSE:     state_d = ST_REDIRECT;
`endif
            ST_REDIRECT:       state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        csr_we_o      = 1'b0;
        csr_waddr_o   = '0;
        csr_wdata_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        flush_o       = 1'b0;
        stall_o       = 1'b0;
        busy_o        = (state_q != ST_IDLE);
        case (state_q)
            ST_SAVE_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
                stall_o     = 1'b1;
            end
            ST_SAVE_CAUSE: begin
                // Synchronous exception: interrupt bit (XLEN-1) stays clear.
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
                stall_o     = 1'b1;
            end
`ifdef TRAP_MSTATUS_EN
            ST_SAVE_STATUS, ST_RESTORE_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_q;
                stall_o     = 1'b1;
            end
`endif
            ST_REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
                flush_o       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_redirect_ctrl
// Table of requests with their expected CSR writes and redirect; each request
// expands into per-cycle expected output records on a scoreboard queue that is
// popped and compared one cycle at a time. Hand-written sequences cover reset
// state, a mid-sequence reset and requests arriving while busy.
// Expectations follow the TRAP_MSTATUS_EN build option.
// -----------------------------------------------------------------------------
module tb_trap_redirect_ctrl;

    localparam int XLEN    = 32;
    localparam int CAUSE_W = 5;

    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] rpc;
        logic        flush;
        logic        stall;
        logic        busy;
    } out_t;

    typedef struct {
        string            name;
        logic             valid;
        logic             branching;
        logic [1:0]       sel;
        logic [31:0]      alu;
        logic [31:0]      pc;
        logic [4:0]       cause;
        logic [31:0]      mtvec;
        logic [31:0]      mepc;
        logic [31:0]      mstatus;
        int               n_wr;
        logic [2:0][11:0] wa;
        logic [2:0][31:0] wd;
        logic             redir;
        logic [31:0]      rpc;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               ex_valid_i, branching_i;
    logic [1:0]         target_sel_i;
    logic [XLEN-1:0]    alu_target_i, ex_pc_i, mtvec_i, mepc_i, mstatus_i;
    logic [CAUSE_W-1:0] exc_cause_i;
    logic               csr_we_o, redirect_o, flush_o, stall_o, busy_o;
    logic [11:0]        csr_waddr_o;
    logic [XLEN-1:0]    csr_wdata_o, redirect_pc_o;

    out_t act;
    out_t exp_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    trap_redirect_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ex_valid_i    (ex_valid_i),
        .branching_i   (branching_i),
        .target_sel_i  (target_sel_i),
        .alu_target_i  (alu_target_i),
        .ex_pc_i       (ex_pc_i),
        .exc_cause_i   (exc_cause_i),
        .mtvec_i       (mtvec_i),
        .mepc_i        (mepc_i),
        .mstatus_i     (mstatus_i),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .flush_o       (flush_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

    always_comb act = {csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o,
                       redirect_pc_o, flush_o, stall_o, busy_o};

    task automatic check(input string name, input out_t a, input out_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%h data=%h redir=%b pc=%h flush=%b stall=%b busy=%b | want we=%b addr=%h data=%h redir=%b pc=%h flush=%b stall=%b busy=%b",
                     name, a.we, a.waddr, a.wdata, a.redir, a.rpc, a.flush, a.stall, a.busy,
                     e.we, e.waddr, e.wdata, e.redir, e.rpc, e.flush, e.stall, e.busy);
        end
    endtask

    function automatic out_t o_idle();
        return '0;
    endfunction

    function automatic out_t o_wr(input logic [11:0] a, input logic [31:0] d);
        out_t o = '0;
        o.we = 1'b1; o.waddr = a; o.wdata = d; o.stall = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t o_redir(input logic [31:0] pc);
        out_t o = '0;
        o.redir = 1'b1; o.rpc = pc; o.flush = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(input string name, input logic v, input logic b,
                                input logic [1:0] sel, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [4:0] cause,
                                input logic [31:0] mtvec, input logic [31:0] mepc,
                                input logic [31:0] mstatus);
        vec_t t;
        t.name = name; t.valid = v; t.branching = b; t.sel = sel; t.alu = alu;
        t.pc = pc; t.cause = cause; t.mtvec = mtvec; t.mepc = mepc;
        t.mstatus = mstatus; t.n_wr = 0; t.wa = '0; t.wd = '0;
        t.redir = 1'b0; t.rpc = '0;
        return t;
    endfunction

    function automatic vec_t add_wr(input vec_t t, input logic [11:0] a, input logic [31:0] d);
        vec_t r = t;
        r.wa[r.n_wr] = a;
        r.wd[r.n_wr] = d;
        r.n_wr++;
        return r;
    endfunction

    function automatic vec_t add_redir(input vec_t t, input logic [31:0] pc);
        vec_t r = t;
        r.redir = 1'b1;
        r.rpc   = pc;
        return r;
    endfunction

    task automatic clear_req();
        ex_valid_i   = 1'b0;
        branching_i  = 1'b0;
        target_sel_i = 2'b00;
    endtask

    task automatic drive(input vec_t v);
        ex_valid_i   = v.valid;
        branching_i  = v.branching;
        target_sel_i = v.sel;
        alu_target_i = v.alu;
        ex_pc_i      = v.pc;
        exc_cause_i  = v.cause;
        mtvec_i      = v.mtvec;
        mepc_i       = v.mepc;
        mstatus_i    = v.mstatus;
    endtask

    // One expected record per cycle after the sampling edge: CSR writes, then
    // the redirect pulse, then a quiet idle cycle.
    task automatic push_expect(input vec_t v);
        for (int i = 0; i < v.n_wr; i++) exp_q.push_back(o_wr(v.wa[i], v.wd[i]));
        if (v.redir) exp_q.push_back(o_redir(v.rpc));
        exp_q.push_back(o_idle());
    endtask

    // junk=1 keeps an ALU request asserted while the sequence runs; the DUT
    // must ignore it until it is back in IDLE.
    task automatic run_vec(input vec_t v, input bit junk);
        out_t e;
        int   cyc = 0;
        drive(v);
        push_expect(v);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            if (junk) begin
                ex_valid_i = 1'b1; branching_i = 1'b1;
                target_sel_i = 2'b00; alu_target_i = 32'h0000_0999;
            end else begin
                clear_req();
            end
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", v.name, cyc), act, e);
            cyc++;
        end
        clear_req();
    endtask

    initial begin
        vec_t t;
        logic [31:0] st_trap_a, st_trap_b, st_mret_a, st_mret_b;

        // mstatus results: trap MPIE<-MIE, MIE<-0, MPP<-11; mret MIE<-MPIE, MPIE<-1, MPP<-11
        st_trap_a = 32'h0000_1880;  // from 0x0000_0008
        st_trap_b = 32'hFFFF_FFF7;  // from 0xFFFF_FFFF
        st_mret_a = 32'h0000_1888;  // from 0x0000_0080
        st_mret_b = 32'h0000_1880;  // from 0x0000_0008

        t = mk("alu_80", 1, 1, 2'b00, 32'h80, 32'h44, 5'd7, 32'h300, 32'h500, 32'h8);
        tbl.push_back(add_redir(t, 32'h80));

        t = mk("trap_a", 1, 1, 2'b01, 32'h77, 32'h100, 5'd2, 32'h203, 32'h900, 32'h8);
        t = add_wr(t, 12'h341, 32'h100);
        t = add_wr(t, 12'h342, 32'h2);
`ifdef TRAP_MSTATUS_EN
        t = add_wr(t, 12'h300, st_trap_a);
`endif
        tbl.push_back(add_redir(t, 32'h200));

        t = mk("mret_a", 1, 1, 2'b10, 32'h55, 32'h120, 5'd3, 32'h400, 32'h104, 32'h80);
`ifdef TRAP_MSTATUS_EN
        t = add_wr(t, 12'h300, st_mret_a);
`endif
        tbl.push_back(add_redir(t, 32'h104));

        tbl.push_back(mk("rsvd", 1, 1, 2'b11, 32'h80, 32'h100, 5'd2, 32'h203, 32'h104, 32'h80));
        tbl.push_back(mk("no_branch", 1, 0, 2'b01, 32'h80, 32'h100, 5'd2, 32'h203, 32'h104, 32'h8));
        tbl.push_back(mk("no_valid", 0, 1, 2'b00, 32'h80, 32'h100, 5'd2, 32'h203, 32'h104, 32'h8));

        t = mk("trap_b", 1, 1, 2'b01, 32'h0, 32'h8000_0004, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        t = add_wr(t, 12'h341, 32'h8000_0004);
        t = add_wr(t, 12'h342, 32'h0000_001F);
`ifdef TRAP_MSTATUS_EN
        t = add_wr(t, 12'h300, st_trap_b);
`endif
        tbl.push_back(add_redir(t, 32'hFFFF_FFFC));

        t = mk("mret_b", 1, 1, 2'b10, 32'h0, 32'h0, 5'd0, 32'h0, 32'hABCD_0000, 32'h8);
`ifdef TRAP_MSTATUS_EN
        t = add_wr(t, 12'h300, st_mret_b);
`endif
        tbl.push_back(add_redir(t, 32'hABCD_0000));

        t = mk("alu_b2b", 1, 1, 2'b00, 32'hDEAD_BEEE, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
        tbl.push_back(add_redir(t, 32'hDEAD_BEEE));

        // ---- reset state
        rst_i = 1'b1;
        clear_req();
        alu_target_i = '0; ex_pc_i = '0; exc_cause_i = '0;
        mtvec_i = '0; mepc_i = '0; mstatus_i = '0;
        @(posedge clk); #1;
        check("reset_hold", act, o_idle());
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("reset_release", act, o_idle());

        // ---- table, applied back to back
        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // ---- requests while busy are dropped
        run_vec(tbl[1], 1'b1);

        // ---- reset during SAVE_CAUSE: no further CSR write, no redirect
        drive(tbl[1]);
        @(posedge clk); #1;
        clear_req();
        check("rst_mid epc", act, o_wr(12'h341, 32'h100));
        @(posedge clk); #1;
        check("rst_mid cause", act, o_wr(12'h342, 32'h2));
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("rst_mid idle", act, o_idle());
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid quiet%0d", i), act, o_idle());
        end

        // ---- sequencer still usable after the reset
        run_vec(tbl[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
